// File: rtl/avr_io_pkg.sv
// Shared I/O-space constants for the ATmega328PB-compatible peripherals.
// Address map defaults and external-interrupt sense-control encodings.
package avr_io_pkg;

    localparam logic [5:0] AVR_PCIFR_ADDR  = 6'h1B;
    localparam logic [5:0] AVR_EIFR_ADDR   = 6'h1C;
    localparam logic [5:0] AVR_EIMSK_ADDR  = 6'h1D;
    localparam logic [7:0] AVR_PCICR_ADDR  = 8'h68;
    localparam logic [7:0] AVR_EICRA_ADDR  = 8'h69;
    localparam logic [7:0] AVR_PCMSK2_ADDR = 8'h6D;

    localparam logic [1:0] ISC_LOW  = 2'b00;
    localparam logic [1:0] ISC_ANY  = 2'b01;
    localparam logic [1:0] ISC_FALL = 2'b10;
    localparam logic [1:0] ISC_RISE = 2'b11;

endpackage

// File: rtl/ext_int_edge.sv
// Sense-control decode for one INTn pin: edge event pulse or
// level request from the synchronized and previous pin samples.
module ext_int_edge
    import avr_io_pkg::*;
(
    input  logic [1:0] isc,
    input  logic       sync_bit,
    input  logic       prev_bit,
    output logic       set_pulse,
    output logic       level_req
);

    always_comb begin
        set_pulse = 1'b0;
        level_req = 1'b0;
        unique case (isc)
            ISC_LOW:  level_req = ~sync_bit;
            ISC_ANY:  set_pulse = sync_bit ^ prev_bit;
            ISC_FALL: set_pulse = prev_bit & ~sync_bit;
            ISC_RISE: set_pulse = sync_bit & ~prev_bit;
        endcase
    end

endmodule

// File: rtl/port_d_ext_int.sv
// Port D INT0/INT1 and PCINT2 controller: pin synchronizer,
// flag registers, interrupt requests and register bus decode.
module port_d_ext_int
    import avr_io_pkg::*;
#(
    parameter logic [5:0] EIFR_ADDR   = AVR_EIFR_ADDR,
    parameter logic [5:0] EIMSK_ADDR  = AVR_EIMSK_ADDR,
    parameter logic [5:0] PCIFR_ADDR  = AVR_PCIFR_ADDR,
    parameter logic [7:0] PCICR_ADDR  = AVR_PCICR_ADDR,
    parameter logic [7:0] EICRA_ADDR  = AVR_EICRA_ADDR,
    parameter logic [7:0] PCMSK2_ADDR = AVR_PCMSK2_ADDR
)(
    input  logic       cp2,
    input  logic       ireset,
    input  logic [5:0] IO_Addr,
    input  logic       iore,
    input  logic       iowe,
    input  logic [7:0] ramadr,
    input  logic       ramre,
    input  logic       ramwe,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out,
    output logic       out_en,
    input  logic [7:0] pin_d,
    output logic       INT0_EN,
    output logic       INT1_EN,
    output logic       PCIE2,
    output logic [7:0] PCINT,
    output logic       int0_irq,
    output logic       int1_irq,
    output logic       pcint2_irq,
    input  logic       int0_ack,
    input  logic       int1_ack,
    input  logic       pcint2_ack
);

    logic [7:0] pin_meta;
    logic [7:0] pin_sync;
    logic [7:0] pin_prev;

    logic [3:0] eicra;
    logic [1:0] eimsk;
    logic [1:0] intf;
    logic       pcie2;
    logic       pcif2;
    logic [7:0] pcmsk2;

    logic eifr_we;
    logic eimsk_we;
    logic pcifr_we;
    logic pcicr_we;
    logic eicra_we;
    logic pcmsk_we;

    logic [1:0] isc_low;
    logic [1:0] set_pulse;
    logic [1:0] level_req;
    logic [1:0] flag_clr;
    logic       pc_set;
    logic       pc_clr;

    logic       io_hit;
    logic [7:0] io_data;
    logic       ext_hit;
    logic [7:0] ext_data;

    assign eifr_we  = iowe & (IO_Addr == EIFR_ADDR);
    assign eimsk_we = iowe & (IO_Addr == EIMSK_ADDR);
    assign pcifr_we = iowe & (IO_Addr == PCIFR_ADDR);
    assign pcicr_we = ramwe & (ramadr == PCICR_ADDR);
    assign eicra_we = ramwe & (ramadr == EICRA_ADDR);
    assign pcmsk_we = ramwe & (ramadr == PCMSK2_ADDR);

    ext_int_edge u_int0 (
        .isc       (eicra[1:0]),
        .sync_bit  (pin_sync[2]),
        .prev_bit  (pin_prev[2]),
        .set_pulse (set_pulse[0]),
        .level_req (level_req[0])
    );

    ext_int_edge u_int1 (
        .isc       (eicra[3:2]),
        .sync_bit  (pin_sync[3]),
        .prev_bit  (pin_prev[3]),
        .set_pulse (set_pulse[1]),
        .level_req (level_req[1])
    );

    assign isc_low[0] = (eicra[1:0] == ISC_LOW);
    assign isc_low[1] = (eicra[3:2] == ISC_LOW);

    // Ack is ignored in level mode; the pin itself holds the request.
    assign flag_clr[0] = (eifr_we & dbus_in[0]) | (int0_ack & ~isc_low[0]);
    assign flag_clr[1] = (eifr_we & dbus_in[1]) | (int1_ack & ~isc_low[1]);

    assign pc_set = |((pin_sync ^ pin_prev) & pcmsk2);
    assign pc_clr = (pcifr_we & dbus_in[2]) | pcint2_ack;

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            pin_meta <= '0;
            pin_sync <= '0;
            pin_prev <= '0;
            eicra    <= '0;
            eimsk    <= '0;
            intf     <= '0;
            pcie2    <= 1'b0;
            pcif2    <= 1'b0;
            pcmsk2   <= '0;
        end else begin
            pin_meta <= pin_d;
            pin_sync <= pin_meta;
            pin_prev <= pin_sync;
            // A hardware set always beats a same-cycle clear.
            intf     <= set_pulse | (intf & ~flag_clr);
            pcif2    <= pc_set | (pcif2 & ~pc_clr);
            if (eimsk_we) eimsk  <= dbus_in[1:0];
            if (eicra_we) eicra  <= dbus_in[3:0];
            if (pcicr_we) pcie2  <= dbus_in[2];
            if (pcmsk_we) pcmsk2 <= dbus_in;
        end
    end

    assign INT0_EN = eimsk[0];
    assign INT1_EN = eimsk[1];
    assign PCIE2   = pcie2;
    assign PCINT   = pcmsk2;

    assign int0_irq   = eimsk[0] & (level_req[0] | (intf[0] & ~isc_low[0]));
    assign int1_irq   = eimsk[1] & (level_req[1] | (intf[1] & ~isc_low[1]));
    assign pcint2_irq = pcif2 & pcie2;

    always_comb begin
        io_hit  = 1'b0;
        io_data = '0;
        if (iore) begin
            if (IO_Addr == EIFR_ADDR) begin
                io_hit  = 1'b1;
                io_data = {6'b0, intf};
            end else if (IO_Addr == EIMSK_ADDR) begin
                io_hit  = 1'b1;
                io_data = {6'b0, eimsk};
            end else if (IO_Addr == PCIFR_ADDR) begin
                io_hit  = 1'b1;
                io_data = {5'b0, pcif2, 2'b0};
            end
        end
    end

    always_comb begin
        ext_hit  = 1'b0;
        ext_data = '0;
        if (ramre) begin
            if (ramadr == PCICR_ADDR) begin
                ext_hit  = 1'b1;
                ext_data = {5'b0, pcie2, 2'b0};
            end else if (ramadr == EICRA_ADDR) begin
                ext_hit  = 1'b1;
                ext_data = {4'b0, eicra};
            end else if (ramadr == PCMSK2_ADDR) begin
                ext_hit  = 1'b1;
                ext_data = pcmsk2;
            end
        end
    end

    assign out_en   = io_hit | ext_hit;
    assign dbus_out = io_data | ext_data;

endmodule

// File: tb/tb_port_d_ext_int.sv
// Directed and randomized checks of port_d_ext_int against a
// cycle-level behavioural model of flags, masks and requests.
module tb_port_d_ext_int;

    logic       cp2 = 1'b0;
    logic       ireset;
    logic [5:0] IO_Addr;
    logic       iore, iowe;
    logic [7:0] ramadr;
    logic       ramre, ramwe;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       out_en;
    logic [7:0] pin_d;
    logic       INT0_EN, INT1_EN, PCIE2;
    logic [7:0] PCINT;
    logic       int0_irq, int1_irq, pcint2_irq;
    logic       int0_ack, int1_ack, pcint2_ack;

    int checks = 0;
    int errors = 0;

    // model state
    logic [3:0] m_eicra;
    logic [1:0] m_eimsk;
    logic [1:0] m_intf;
    logic       m_pcie;
    logic       m_pcif;
    logic [7:0] m_pcmsk;
    logic [7:0] q[$];

    port_d_ext_int dut (
        .cp2        (cp2),
        .ireset     (ireset),
        .IO_Addr    (IO_Addr),
        .iore       (iore),
        .iowe       (iowe),
        .ramadr     (ramadr),
        .ramre      (ramre),
        .ramwe      (ramwe),
        .dbus_in    (dbus_in),
        .dbus_out   (dbus_out),
        .out_en     (out_en),
        .pin_d      (pin_d),
        .INT0_EN    (INT0_EN),
        .INT1_EN    (INT1_EN),
        .PCIE2      (PCIE2),
        .PCINT      (PCINT),
        .int0_irq   (int0_irq),
        .int1_irq   (int1_irq),
        .pcint2_irq (pcint2_irq),
        .int0_ack   (int0_ack),
        .int1_ack   (int1_ack),
        .pcint2_ack (pcint2_ack)
    );

    always #5 cp2 = ~cp2;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_eicra = '0;
        m_eimsk = '0;
        m_intf  = '0;
        m_pcie  = 1'b0;
        m_pcif  = 1'b0;
        m_pcmsk = '0;
        q = '{8'h00, 8'h00, 8'h00};
    endtask

    // Trigger rule: 0 low level, 1 any change, 2 falling, 3 rising.
    function automatic bit edge_ev(input logic [1:0] mode,
                                   input logic now_v, input logic old_v);
        case (mode)
            2'd1:    return now_v != old_v;
            2'd2:    return old_v && !now_v;
            2'd3:    return now_v && !old_v;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [8:0] mrd(input bit ext, input logic [7:0] a);
        if (!ext) begin
            case (a[5:0])
                6'h1C:   return {1'b1, 6'b0, m_intf};
                6'h1D:   return {1'b1, 6'b0, m_eimsk};
                6'h1B:   return {1'b1, 5'b0, m_pcif, 2'b0};
                default: return 9'h000;
            endcase
        end
        case (a)
            8'h68:   return {1'b1, 5'b0, m_pcie, 2'b0};
            8'h69:   return {1'b1, 4'b0, m_eicra};
            8'h6D:   return {1'b1, m_pcmsk};
            default: return 9'h000;
        endcase
    endfunction

    task automatic check_outputs(input string ph);
        logic s0, s1;
        s0 = q[1][2];
        s1 = q[1][3];
        chk({ph, "_int0_irq"}, {7'b0, int0_irq},
            {7'b0, m_eimsk[0] && (m_eicra[1:0] == 2'd0 ? !s0 : m_intf[0])});
        chk({ph, "_int1_irq"}, {7'b0, int1_irq},
            {7'b0, m_eimsk[1] && (m_eicra[3:2] == 2'd0 ? !s1 : m_intf[1])});
        chk({ph, "_pcint2_irq"}, {7'b0, pcint2_irq}, {7'b0, m_pcif && m_pcie});
        chk({ph, "_en"}, {5'b0, PCIE2, INT1_EN, INT0_EN},
            {5'b0, m_pcie, m_eimsk});
        chk({ph, "_pcint"}, PCINT, m_pcmsk);
    endtask

    task automatic tick();
        logic [7:0] s, p, pv;
        logic [1:0] nf;
        logic       np;
        bit         eifr_w, pcifr_w;
        s  = q[1];
        p  = q[2];
        pv = pin_d;
        eifr_w  = iowe && IO_Addr == 6'h1C;
        pcifr_w = iowe && IO_Addr == 6'h1B;
        nf[0] = edge_ev(m_eicra[1:0], s[2], p[2]) ||
                (m_intf[0] && !(eifr_w && dbus_in[0]) &&
                 !(int0_ack && m_eicra[1:0] != 2'd0));
        nf[1] = edge_ev(m_eicra[3:2], s[3], p[3]) ||
                (m_intf[1] && !(eifr_w && dbus_in[1]) &&
                 !(int1_ack && m_eicra[3:2] != 2'd0));
        np = (|((s ^ p) & m_pcmsk)) ||
             (m_pcif && !(pcifr_w && dbus_in[2]) && !pcint2_ack);
        @(posedge cp2);
        m_intf = nf;
        m_pcif = np;
        if (iowe && IO_Addr == 6'h1D) m_eimsk = dbus_in[1:0];
        if (ramwe && ramadr == 8'h68) m_pcie = dbus_in[2];
        if (ramwe && ramadr == 8'h69) m_eicra = dbus_in[3:0];
        if (ramwe && ramadr == 8'h6D) m_pcmsk = dbus_in;
        q.push_front(pv);
        void'(q.pop_back());
        #1;
        check_outputs("cyc");
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input bit ext, input logic [7:0] a, input string tag,
                      output logic [7:0] d);
        logic [8:0] e;
        e = mrd(ext, a);
        if (ext) begin
            ramadr = a;
            ramre  = 1'b1;
        end else begin
            IO_Addr = a[5:0];
            iore    = 1'b1;
        end
        #1;
        d = dbus_out;
        chk({tag, "_data"}, dbus_out, e[7:0]);
        chk({tag, "_en"}, {7'b0, out_en}, {7'b0, e[8]});
        iore  = 1'b0;
        ramre = 1'b0;
    endtask

    task automatic wr_io(input logic [5:0] a, input logic [7:0] d);
        IO_Addr = a;
        dbus_in = d;
        iowe    = 1'b1;
        tick();
        iowe    = 1'b0;
    endtask

    task automatic wr_ext(input logic [7:0] a, input logic [7:0] d);
        ramadr  = a;
        dbus_in = d;
        ramwe   = 1'b1;
        tick();
        ramwe   = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] addrs [6];
        int         k;
        addrs = '{8'h1C, 8'h1D, 8'h1B, 8'h68, 8'h69, 8'h6D};
        ireset = 1'b0;
        IO_Addr = '0; iore = 0; iowe = 0;
        ramadr = '0; ramre = 0; ramwe = 0;
        dbus_in = '0; pin_d = '0;
        int0_ack = 0; int1_ack = 0; pcint2_ack = 0;
        model_reset();
        #2;
        check_outputs("rst");
        rd(0, 8'h1C, "rst_eifr", d);
        rd(1, 8'h69, "rst_eicra", d);
        rd(0, 8'h2A, "unmapped_io", d);
        rd(1, 8'h6A, "unmapped_ext", d);
        @(negedge cp2);
        ireset = 1'b1;
        ticks(3);

        // INT0 rising edge, cleared by writing 1
        wr_ext(8'h69, 8'h03);
        wr_io(6'h1D, 8'h01);
        pin_d[2] = 1'b1;
        tick(); chk("t1_lag1", {7'b0, int0_irq}, 8'h00);
        tick(); chk("t1_lag2", {7'b0, int0_irq}, 8'h00);
        tick(); chk("t1_irq", {7'b0, int0_irq}, 8'h01);
        rd(0, 8'h1C, "t1_eifr", d); chk("t1_eifr_val", d, 8'h01);
        wr_io(6'h1C, 8'h01);
        chk("t1_clr_irq", {7'b0, int0_irq}, 8'h00);
        rd(0, 8'h1C, "t1_eifr2", d); chk("t1_eifr2_val", d, 8'h00);

        // INT1 falling edge, cleared by ack
        pin_d[3] = 1'b1;
        ticks(3);
        wr_ext(8'h69, 8'h08);
        wr_io(6'h1D, 8'h02);
        pin_d[3] = 1'b0;
        ticks(3);
        chk("t2_irq", {7'b0, int1_irq}, 8'h01);
        rd(0, 8'h1C, "t2_eifr", d); chk("t2_eifr_val", d, 8'h02);
        int1_ack = 1'b1;
        tick();
        int1_ack = 1'b0;
        chk("t2_ack_irq", {7'b0, int1_irq}, 8'h00);
        rd(0, 8'h1C, "t2_eifr2", d); chk("t2_eifr2_val", d, 8'h00);

        // INT0 low level
        wr_ext(8'h69, 8'h00);
        wr_io(6'h1D, 8'h01);
        chk("t3_idle", {7'b0, int0_irq}, 8'h00);
        pin_d[2] = 1'b0;
        tick(); chk("t3_lag", {7'b0, int0_irq}, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick(); chk("t3_low", {7'b0, int0_irq}, 8'h01);
        end
        rd(0, 8'h1C, "t3_eifr", d); chk("t3_eifr_val", d, 8'h00);
        pin_d[2] = 1'b1;
        tick(); chk("t3_hold", {7'b0, int0_irq}, 8'h01);
        tick(); chk("t3_release", {7'b0, int0_irq}, 8'h00);

        // pin-change masking
        wr_ext(8'h6D, 8'h81);
        wr_ext(8'h68, 8'h04);
        pin_d[4] = 1'b1;
        ticks(4);
        rd(0, 8'h1B, "t4_masked", d); chk("t4_masked_val", d, 8'h00);
        pin_d[7] = 1'b1;
        ticks(3);
        rd(0, 8'h1B, "t4_pcifr", d); chk("t4_pcifr_val", d, 8'h04);
        chk("t4_irq", {7'b0, pcint2_irq}, 8'h01);
        wr_io(6'h1B, 8'h04);
        wr_ext(8'h68, 8'h00);
        pin_d[7] = 1'b0;
        ticks(3);
        rd(0, 8'h1B, "t4_noie", d); chk("t4_noie_val", d, 8'h04);
        chk("t4_noie_irq", {7'b0, pcint2_irq}, 8'h00);

        // set/clear collision on INT0
        wr_ext(8'h69, 8'h03);
        pin_d[2] = 1'b0;
        ticks(3);
        pin_d[2] = 1'b1;
        ticks(3);
        pin_d[2] = 1'b0;
        ticks(3);
        pin_d[2] = 1'b1;
        ticks(2);
        wr_io(6'h1C, 8'h01);
        rd(0, 8'h1C, "t5_collide", d); chk("t5_collide_val", d, 8'h01);
        chk("t5_irq", {7'b0, int0_irq}, 8'h01);
        wr_io(6'h1C, 8'h01);
        rd(0, 8'h1C, "t5_clear", d); chk("t5_clear_val", d, 8'h00);

        // reset mid-operation
        wr_ext(8'h69, 8'h0F);
        wr_io(6'h1D, 8'h03);
        wr_ext(8'h68, 8'h04);
        wr_ext(8'h6D, 8'hFF);
        pin_d = 8'h00;
        ticks(3);
        pin_d = 8'h0C;
        ticks(3);
        chk("t6_pre", {5'b0, pcint2_irq, int1_irq, int0_irq}, 8'h07);
        #3;
        ireset = 1'b0;
        model_reset();
        #1;
        chk("t6_irqs", {5'b0, pcint2_irq, int1_irq, int0_irq}, 8'h00);
        chk("t6_masks", {5'b0, PCIE2, INT1_EN, INT0_EN}, 8'h00);
        chk("t6_pcint", PCINT, 8'h00);
        rd(0, 8'h1C, "t6_eifr", d); chk("t6_eifr_val", d, 8'h00);
        rd(0, 8'h1B, "t6_pcifr", d); chk("t6_pcifr_val", d, 8'h00);
        rd(1, 8'h69, "t6_eicra", d); chk("t6_eicra_val", d, 8'h00);
        @(negedge cp2);
        ireset = 1'b1;
        ticks(4);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) pin_d = 8'($urandom);
            int0_ack   = ($urandom_range(0, 7) == 0);
            int1_ack   = ($urandom_range(0, 7) == 0);
            pcint2_ack = ($urandom_range(0, 7) == 0);
            k = $urandom_range(0, 9);
            dbus_in = 8'($urandom);
            if (k == 0) begin
                IO_Addr = addrs[$urandom_range(0, 2)][5:0];
                iowe    = 1'b1;
            end else if (k == 1) begin
                ramadr = addrs[$urandom_range(3, 5)];
                ramwe  = 1'b1;
            end
            tick();
            iowe = 0; ramwe = 0;
            int0_ack = 0; int1_ack = 0; pcint2_ack = 0;
            k = $urandom_range(0, 6);
            if (k < 3) rd(0, addrs[k], "rnd_io", d);
            else if (k < 6) rd(1, addrs[k], "rnd_ext", d);
            else rd(1, 8'($urandom), "rnd_any", d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
